// File: rtl/regfile_mp.sv
// Multi-ported register file with two write ports (M over E), optional write-to-read
// forwarding, a per-register busy scoreboard and a saturating commit counter.
module regfile_mp #(
  parameter int              WIDTH  = 32,
  parameter int              NREGS  = 8,
  parameter int              AW     = 4,
  parameter int              NREAD  = 2,
  parameter logic [AW-1:0]   RNONE  = 4'hF,
  parameter int              BYPASS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREAD*AW-1:0]    src,
  output logic [NREAD*WIDTH-1:0] val,
  output logic [NREAD-1:0]       busy,
  input  logic [AW-1:0]          dstE,
  input  logic [WIDTH-1:0]       valE,
  input  logic [AW-1:0]          dstM,
  input  logic [WIDTH-1:0]       valM,
  input  logic                   rsv_valid,
  input  logic [AW-1:0]          rsv_reg,
  output logic [7:0]             wr_count
);

  function automatic logic id_valid(input logic [AW-1:0] id);
    return (id != RNONE) && (int'(id) < NREGS);
  endfunction

  logic [WIDTH-1:0] regs_reg [NREGS];
  logic [NREGS-1:0] busy_reg;
  logic [7:0]       wr_count_reg;

  logic e_we, m_we, rsv_we;
  assign e_we   = id_valid(dstE);
  assign m_we   = id_valid(dstM);
  assign rsv_we = rsv_valid && id_valid(rsv_reg);

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      localparam logic [AW-1:0] ID = AW'(gi);
      logic hit_m, hit_e, hit_rsv;
      assign hit_m   = m_we && (dstM == ID);
      assign hit_e   = e_we && (dstE == ID);
      assign hit_rsv = rsv_we && (rsv_reg == ID);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          regs_reg[gi] <= '0;
          busy_reg[gi] <= 1'b0;
        end else begin
          if (hit_m)
            regs_reg[gi] <= valM;
          else if (hit_e)
            regs_reg[gi] <= valE;
          // A reservation landing on the same edge as a write keeps the register busy.
          if (hit_rsv)
            busy_reg[gi] <= 1'b1;
          else if (hit_m || hit_e)
            busy_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      wr_count_reg <= 8'd0;
    else if ((e_we || m_we) && (wr_count_reg != 8'hFF))
      wr_count_reg <= wr_count_reg + 8'd1;
  end

  assign wr_count = wr_count_reg;

  generate
    for (gi = 0; gi < NREAD; gi++) begin : g_rd
      logic [AW-1:0]    s;
      logic             s_ok;
      logic [WIDTH-1:0] rd_next;
      logic             bz_next;
      assign s    = src[gi*AW +: AW];
      assign s_ok = id_valid(s);

      always_comb begin
        rd_next = '0;
        bz_next = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
          if (s_ok && (s == AW'(r))) begin
            rd_next = regs_reg[r];
            bz_next = busy_reg[r];
          end
        end
        if ((BYPASS != 0) && s_ok) begin
          if (m_we && (s == dstM))
            rd_next = valM;
          else if (e_we && (s == dstE))
            rd_next = valE;
        end
        // Forwarded data must not leak out while the file is held in reset.
        if (!rst) begin
          rd_next = '0;
          bz_next = 1'b0;
        end
      end

      assign val[gi*WIDTH +: WIDTH] = rd_next;
      assign busy[gi]               = bz_next;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a forwarding instance driven by a vector table plus
// hand-written sequences, and a non-forwarding twin sharing the same stimulus.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  src;
  logic [63:0] val, val_nb;
  logic [1:0]  busy, busy_nb;
  logic [3:0]  dstE, dstM, rsv_reg;
  logic [31:0] valE, valM;
  logic        rsv_valid;
  logic [7:0]  wr_count, wr_count_nb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .src(src), .val(val), .busy(busy),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .rsv_valid(rsv_valid), .rsv_reg(rsv_reg), .wr_count(wr_count)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .src(src), .val(val_nb), .busy(busy_nb),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .rsv_valid(rsv_valid), .rsv_reg(rsv_reg), .wr_count(wr_count_nb)
  );

  typedef struct {
    logic [3:0]  src0, src1, dstE, dstM, rsv_reg;
    logic        rsv_valid;
    logic [31:0] valE, valM, exp_v0, exp_v1;
    logic [1:0]  exp_busy;
    logic [7:0]  exp_wr;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(logic [3:0] s0, logic [3:0] s1, logic [3:0] de, logic [31:0] ve,
                              logic [3:0] dm, logic [31:0] vm, logic rv, logic [3:0] rr,
                              logic [31:0] e0, logic [31:0] e1, logic [1:0] eb, logic [7:0] ew);
    vec_t v;
    v.src0 = s0; v.src1 = s1; v.dstE = de; v.valE = ve; v.dstM = dm; v.valM = vm;
    v.rsv_valid = rv; v.rsv_reg = rr; v.exp_v0 = e0; v.exp_v1 = e1;
    v.exp_busy = eb; v.exp_wr = ew;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    dstE = 4'hF; valE = '0; dstM = 4'hF; valM = '0; rsv_valid = 1'b0; rsv_reg = 4'hF;
  endtask

  initial begin
    rst = 1'b0;
    src = 8'hFF;
    idle();

    // Outputs sampled before each edge, so forwarded data is visible and wr_count is pre-edge.
    //            s0    s1    dstE  valE          dstM  valM          rv    rr    v0            v1            busy   wr
    vecs[0]  = mk(4'd0, 4'd7, 4'hF, 32'h0,        4'hF, 32'h0,        1'b0, 4'hF, 32'h0,        32'h0,        2'b00, 8'd0);
    vecs[1]  = mk(4'd3, 4'd1, 4'd3, 32'h1234,     4'd3, 32'hABCD,     1'b0, 4'hF, 32'hABCD,     32'h0,        2'b00, 8'd0);
    vecs[2]  = mk(4'd3, 4'd2, 4'hF, 32'h0,        4'd2, 32'h55,       1'b0, 4'hF, 32'hABCD,     32'h55,       2'b00, 8'd1);
    vecs[3]  = mk(4'd2, 4'hF, 4'hF, 32'h0,        4'hF, 32'h0,        1'b1, 4'd5, 32'h55,       32'h0,        2'b00, 8'd2);
    vecs[4]  = mk(4'd5, 4'd9, 4'd5, 32'h77,       4'hF, 32'h0,        1'b0, 4'hF, 32'h77,       32'h0,        2'b01, 8'd2);
    vecs[5]  = mk(4'd5, 4'd3, 4'd5, 32'h88,       4'hF, 32'h0,        1'b1, 4'd5, 32'h88,       32'hABCD,     2'b00, 8'd3);
    vecs[6]  = mk(4'd5, 4'd2, 4'hF, 32'h0,        4'hF, 32'h0,        1'b0, 4'hF, 32'h88,       32'h55,       2'b01, 8'd4);
    vecs[7]  = mk(4'hF, 4'd9, 4'hF, 32'h0,        4'd9, 32'hDEAD,     1'b1, 4'd9, 32'h0,        32'h0,        2'b00, 8'd4);
    vecs[8]  = mk(4'd3, 4'd1, 4'hF, 32'h0,        4'hF, 32'h0,        1'b0, 4'hF, 32'hABCD,     32'h0,        2'b00, 8'd4);
    vecs[9]  = mk(4'd1, 4'd4, 4'd1, 32'h11,       4'd4, 32'h44,       1'b0, 4'hF, 32'h11,       32'h44,       2'b00, 8'd4);
    vecs[10] = mk(4'd1, 4'd4, 4'hF, 32'h0,        4'hF, 32'h0,        1'b0, 4'hF, 32'h11,       32'h44,       2'b00, 8'd5);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      src = {vecs[i].src1, vecs[i].src0};
      dstE = vecs[i].dstE; valE = vecs[i].valE;
      dstM = vecs[i].dstM; valM = vecs[i].valM;
      rsv_valid = vecs[i].rsv_valid; rsv_reg = vecs[i].rsv_reg;
      @(negedge clk);
      check($sformatf("vec%0d val0", i), val[31:0], vecs[i].exp_v0);
      check($sformatf("vec%0d val1", i), val[63:32], vecs[i].exp_v1);
      check($sformatf("vec%0d busy", i), {30'd0, busy}, {30'd0, vecs[i].exp_busy});
      check($sformatf("vec%0d wr_count", i), {24'd0, wr_count}, {24'd0, vecs[i].exp_wr});
      $display("vec%0d src=%h val=%h busy=%b wr=%0d", i, src, val, busy, wr_count);
      @(posedge clk); #1;
    end

    // Same-cycle write: forwarding instance sees the new value, the other the old one.
    idle();
    src = {4'hF, 4'd2};
    dstM = 4'd2; valM = 32'h66;
    @(negedge clk);
    check("bypass val0", val[31:0], 32'h66);
    check("nobypass val0", val_nb[31:0], 32'h55);
    $display("bypass seq val=%h val_nb=%h", val[31:0], val_nb[31:0]);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check("nobypass after edge", val_nb[31:0], 32'h66);
    check("bypass wr_count", {24'd0, wr_count}, 32'd6);
    $display("post-write val=%h val_nb=%h wr=%0d", val[31:0], val_nb[31:0], wr_count);

    // Saturation of the commit counter.
    @(posedge clk); #1;
    for (int i = 0; i < 300; i++) begin
      dstE = 4'(i % 8); valE = 32'(i + 1);
      @(posedge clk); #1;
    end
    idle();
    src = {4'd3, 4'd7};
    @(negedge clk);
    check("sat wr_count", {24'd0, wr_count}, 32'd255);
    check("sat reg7", val[31:0], 32'd296);
    check("sat reg3", val[63:32], 32'd300);
    $display("saturation wr=%0d r7=%h r3=%h", wr_count, val[31:0], val[63:32]);

    // Reset pulsed between edges, with a reservation and write pending.
    @(posedge clk); #1;
    src = {4'd5, 4'd7};
    dstM = 4'd7; valM = 32'h99; rsv_valid = 1'b1; rsv_reg = 4'd5;
    #2 rst = 1'b0;
    #1;
    check("rst val0", val[31:0], 32'h0);
    check("rst val1", val[63:32], 32'h0);
    check("rst busy", {30'd0, busy}, 32'd0);
    check("rst wr_count", {24'd0, wr_count}, 32'd0);
    check("rst nobypass val0", val_nb[31:0], 32'h0);
    $display("in reset val=%h busy=%b wr=%0d", val, busy, wr_count);
    @(posedge clk); #1;
    check("rst held wr_count", {24'd0, wr_count}, 32'd0);
    idle();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post-rst val0", val[31:0], 32'h0);
    check("post-rst busy", {30'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("post-rst wr_count", {24'd0, wr_count}, 32'd0);
    check("post-rst reg5 busy", {30'd0, busy}, 32'd0);
    $display("after reset val=%h busy=%b wr=%0d", val, busy, wr_count);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter NREGS, default 8, number of architectural registers (2..15).
REQ-003 SHALL have parameter AW, default 4, register-ID width in bits.
REQ-004 SHALL have parameter NREAD, default 2, number of read ports (1..4).
REQ-005 SHALL have parameter RNONE, default 4'hF, the "no register" ID.
REQ-006 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-007 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-009 SHALL have port src  input  NREAD*AW  read IDs; port i occupies bits [i*AW +: AW].
REQ-010 SHALL have port val  output  NREAD*WIDTH  read data; port i occupies bits [i*WIDTH +: WIDTH].
REQ-011 SHALL have port busy  output  NREAD  scoreboard bit of the register addressed by port i.
REQ-012 SHALL have port dstE  input  AW  write-port-E destination ID.
REQ-013 SHALL have port valE  input  WIDTH  write-port-E data.
REQ-014 SHALL have port dstM  input  AW  write-port-M destination ID.
REQ-015 SHALL have port valM  input  WIDTH  write-port-M data.
REQ-016 SHALL have port rsv_valid  input  1  reserve request this cycle.
REQ-017 SHALL have port rsv_reg  input  AW  register ID to mark busy.
REQ-018 SHALL have port wr_count  output  8  saturating count of committed register writes since reset.

Function
REQ-019 SHALL hold NREGS registers of WIDTH bits and NREGS busy bits.
REQ-020 SHALL treat an ID as valid only if it is not RNONE and is less than NREGS; all other IDs are "none".
REQ-021 SHALL, on a rising clk edge, write valE to regs[dstE] when dstE is valid, and valM to regs[dstM] when dstM is valid.
REQ-022 SHALL, when dstE equals dstM and both are valid, write valM only (M has priority).
REQ-023 SHALL drive each read port combinationally: regs[src_i] for a valid ID, 0 for a "none" ID (no held or latched value).
REQ-024 SHALL, when BYPASS=1 and src_i is valid and equals a valid dstM, return valM; otherwise, if it equals a valid dstE, return valE; otherwise return regs[src_i].
REQ-025 SHALL, when BYPASS=0, return the pre-edge register contents regardless of same-cycle writes.
REQ-026 SHALL set busy bit of rsv_reg on a rising edge when rsv_valid=1 and rsv_reg is valid.
REQ-027 SHALL clear busy bit of every register written on that edge (via E or M).
REQ-028 SHALL, when a reserve and a write target the same register on the same edge, leave the busy bit set (reserve wins).
REQ-029 SHALL drive busy[i] combinationally from the busy bit of src_i, and 0 for a "none" ID; the busy output is not bypassed.
REQ-030 SHALL increment wr_count by 1 per edge on which at least one valid write occurs; a same-register E/M collision counts as one write; wr_count saturates at 255.
REQ-031 SHALL give write latency of one edge: a write is visible on an unbypassed read from the cycle after the edge.

Reset
REQ-032 SHALL, while rst=0, asynchronously clear all registers to 0, all busy bits to 0 and wr_count to 0, independent of clk.
REQ-033 SHALL, during reset, drive val=0 for every port, busy=0 and wr_count=0; writes and reserves are ignored while rst=0.
REQ-034 SHALL, when rst is asserted mid-operation (pending reserves or writes), discard them with no partial update after deassertion.

Verification
REQ-035 SHALL cover: after reset, src0=0,src1=7 -> val0=0,val1=0,busy=0,wr_count=0.
REQ-036 SHALL cover: dstE=3,valE=32'h1234 and dstM=3,valM=32'hABCD on one edge -> regs[3]=32'hABCD, wr_count=1.
REQ-037 SHALL cover: BYPASS=1, dstM=2,valM=32'h55 with src0=2 in same cycle -> val0=32'h55 before the edge; BYPASS=0 -> val0 = old value 0.
REQ-038 SHALL cover: rsv_valid=1,rsv_reg=5 on edge N -> busy for src=5 is 1; dstE=5 on edge N+1 -> busy is 0; reserve and dstE=5 on one edge -> busy is 1.
REQ-039 SHALL cover: src=RNONE and src=9 (NREGS=8) -> val=0, busy=0; dstE=RNONE -> no write, wr_count unchanged.
REQ-040 SHALL cover: 300 consecutive valid writes -> wr_count=255; rst pulsed low between edges -> all registers 0 immediately, wr_count=0.
